// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_types (package)
// Description : Shared RV32I pipeline types for the decode stage: opcode and
//               immediate-format enums, decode FSM states, IF/ID and ID/EX
//               stage payloads, and the immediate generator.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

  // Base opcodes recognised by the decoder
  typedef enum logic [6:0] {
    OP_LUI   = 7'b0110111,
    OP_AUIPC = 7'b0010111,
    OP_JAL   = 7'b1101111,
    OP_JALR  = 7'b1100111,
    OP_BR    = 7'b1100011,
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011,
    OP_IMM   = 7'b0010011,
    OP_REG   = 7'b0110011
  } rv32i_opcode_t;

  // Immediate encodings; FMT_R means the instruction carries no immediate
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } imm_fmt_t;

  // Decode-stage view of the single imem request slot
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // nothing outstanding
    ST_WAIT = 2'd1,  // wanted request outstanding
    ST_KILL = 2'd2,  // wrong-path request outstanding
    ST_HELD = 2'd3   // response captured while the pipe is stalled
  } id_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [63:0] order;
    logic        valid;
  } if_id_stage_reg_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [63:0] order;
    logic        valid;
    logic        illegal;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [31:0] imm;
  } id_ex_stage_reg_t;

  // Fields produced by the combinational decoder
  typedef struct packed {
    logic        illegal;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [31:0] imm;
  } decoded_t;

  // Sign-extended immediate for the given encoding format
  function automatic logic [31:0] imm_gen(input logic [31:0] inst, input imm_fmt_t fmt);
    logic [31:0] imm;
    imm = 32'h0;
    case (fmt)
      FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm = {inst[31:12], 12'h000};
      FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = 32'h0;
    endcase
    return imm;
  endfunction

  // ID/EX entry carrying no instruction
  function automatic id_ex_stage_reg_t bubble_entry(input logic [31:0] inst);
    id_ex_stage_reg_t e;
    e      = '0;
    e.inst = inst;
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_decoder.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_decoder
// Description : Purely combinational RV32I field decoder. Splits the word
//               into its fields, builds the immediate and zeroes register
//               indices the instruction format does not use.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_decoder
  import rv32i_types::*;
(
  input  logic [31:0] inst,
  output decoded_t    dec
);

  imm_fmt_t fmt;
  logic     known;

  // Classify the opcode into an immediate format and flag unknown opcodes
  always_comb begin
    fmt   = FMT_R;
    known = 1'b1;
    case (inst[6:0])
      OP_LUI, OP_AUIPC:         fmt = FMT_U;
      OP_JAL:                   fmt = FMT_J;
      OP_JALR, OP_LOAD, OP_IMM: fmt = FMT_I;
      OP_BR:                    fmt = FMT_B;
      OP_STORE:                 fmt = FMT_S;
      OP_REG:                   fmt = FMT_R;
      default:                  known = 1'b0;
    endcase
  end

  // Extract fields, then mask the register indices the format does not use
  always_comb begin
    dec.illegal = ~known;
    dec.opcode  = inst[6:0];
    dec.funct3  = inst[14:12];
    dec.funct7  = inst[31:25];
    dec.rd_s    = inst[11:7];
    dec.rs1_s   = inst[19:15];
    dec.rs2_s   = inst[24:20];
    dec.imm     = imm_gen(inst, fmt);
    case (fmt)
      FMT_S, FMT_B: dec.rd_s = 5'd0;
      FMT_U, FMT_J: begin
        dec.rs1_s = 5'd0;
        dec.rs2_s = 5'd0;
      end
      FMT_I:        dec.rs2_s = 5'd0;
      default:      ;
    endcase
    if (!known) begin
      dec.imm  = 32'h0;
      dec.rd_s = 5'd0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : ID stage behind fetch. Tracks the one outstanding imem read,
//               pairs its response with the pc/order captured at issue,
//               buffers a response that lands during a stall, discards
//               wrong-path responses after a flush, throttles fetch via go,
//               and registers the decoded RV32I payload into ID/EX.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
  import rv32i_types::*;
#(
  parameter logic [31:0] BUBBLE_INST = 32'h00000013,
  parameter int unsigned REG_IDX_W   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   flush,
  input  if_id_stage_reg_t       if_id_stage_reg,
  input  logic                   imem_trigger,
  input  logic                   imem_resp,
  input  logic [31:0]            imem_rdata,
  output logic                   go,
  output logic [REG_IDX_W-1:0]   rs1_s,
  output logic [REG_IDX_W-1:0]   rs2_s,
  output id_ex_stage_reg_t       id_ex_stage_reg
);

  localparam id_ex_stage_reg_t c_id_ex_bubble = bubble_entry(BUBBLE_INST);

  id_state_t        state_q, state_d;
  if_id_stage_reg_t meta_q, meta_d;
  logic [31:0]      inst_buf_q, inst_buf_d;
  id_ex_stage_reg_t id_ex_q, id_ex_d;

  id_state_t        issue_state;
  id_state_t        after_state;
  logic             emit;
  logic [31:0]      emit_inst;
  decoded_t         dec;

  // State a newly issued request starts in: wanted unless it is already dead
  always_comb begin
    issue_state = (!flush && if_id_stage_reg.valid) ? ST_WAIT : ST_KILL;
    after_state = imem_trigger ? issue_state : ST_IDLE;
  end

  // Request-tracking FSM: next state, fetch permission and emit selection
  always_comb begin
    state_d    = state_q;
    inst_buf_d = inst_buf_q;
    go         = 1'b0;
    emit       = 1'b0;
    emit_inst  = imem_rdata;
    case (state_q)
      ST_IDLE: begin
        go = 1'b1;
        if (imem_trigger) state_d = issue_state;
      end
      ST_WAIT: begin
        if (imem_resp) begin
          if (flush) begin
            go      = 1'b1;
            state_d = after_state;
          end else if (!stall) begin
            go      = 1'b1;
            emit    = 1'b1;
            state_d = after_state;
          end else begin
            inst_buf_d = imem_rdata;
            state_d    = ST_HELD;
          end
        end else if (flush) begin
          state_d = ST_KILL;
        end
      end
      ST_KILL: begin
        if (imem_resp) begin
          go      = 1'b1;
          state_d = after_state;
        end
      end
      ST_HELD: begin
        emit_inst = inst_buf_q;
        if (flush) begin
          state_d = ST_IDLE;
        end else if (!stall) begin
          go      = 1'b1;
          emit    = 1'b1;
          state_d = after_state;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture issue metadata whenever fetch fires a request
  always_comb begin
    meta_d = imem_trigger ? if_id_stage_reg : meta_q;
  end

  rv32i_decoder u_decoder (
    .inst (emit_inst),
    .dec  (dec)
  );

  // Regfile read indices follow the instruction leaving this cycle only
  always_comb begin
    rs1_s = emit ? dec.rs1_s : '0;
    rs2_s = emit ? dec.rs2_s : '0;
  end

  // ID/EX update: flush beats stall, stall holds, otherwise emit or bubble
  always_comb begin
    id_ex_d = c_id_ex_bubble;
    if (flush) begin
      id_ex_d = c_id_ex_bubble;
    end else if (stall) begin
      id_ex_d = id_ex_q;
    end else if (emit) begin
      id_ex_d.pc      = meta_q.pc;
      id_ex_d.pc_next = meta_q.pc_next;
      id_ex_d.order   = meta_q.order;
      id_ex_d.valid   = 1'b1;
      id_ex_d.illegal = dec.illegal;
      id_ex_d.inst    = emit_inst;
      id_ex_d.opcode  = dec.opcode;
      id_ex_d.funct3  = dec.funct3;
      id_ex_d.funct7  = dec.funct7;
      id_ex_d.rd_s    = dec.rd_s;
      id_ex_d.rs1_s   = dec.rs1_s;
      id_ex_d.rs2_s   = dec.rs2_s;
      id_ex_d.imm     = dec.imm;
    end
  end

  // State, metadata, response buffer and ID/EX registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      meta_q     <= '0;
      inst_buf_q <= 32'h0;
      id_ex_q    <= c_id_ex_bubble;
    end else begin
      state_q    <= state_d;
      meta_q     <= meta_d;
      inst_buf_q <= inst_buf_d;
      id_ex_q    <= id_ex_d;
    end
  end

  assign id_ex_stage_reg = id_ex_q;

  // Fetch may only issue when the single request slot is free
  assert property (@(posedge clk) disable iff (rst) imem_trigger |-> go);

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Directed self-checking bench for decode_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;
  import rv32i_types::*;

  logic             clk;
  logic             rst;
  logic             stall;
  logic             flush;
  if_id_stage_reg_t if_id;
  logic             imem_trigger;
  logic             imem_resp;
  logic [31:0]      imem_rdata;
  logic             go;
  logic [4:0]       rs1_s;
  logic [4:0]       rs2_s;
  id_ex_stage_reg_t id_ex;

  int n_checks;
  int n_pass;

  decode_stage #(
    .BUBBLE_INST (32'h00000013),
    .REG_IDX_W   (5)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .if_id_stage_reg (if_id),
    .imem_trigger    (imem_trigger),
    .imem_resp       (imem_resp),
    .imem_rdata      (imem_rdata),
    .go              (go),
    .rs1_s           (rs1_s),
    .rs2_s           (rs2_s),
    .id_ex_stage_reg (id_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_idle();
    imem_trigger = 1'b0;
    imem_resp    = 1'b0;
    imem_rdata   = 32'h0;
    stall        = 1'b0;
    flush        = 1'b0;
    if_id        = '0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [63:0] ord, input logic v);
    imem_trigger  = 1'b1;
    if_id.pc      = pc;
    if_id.pc_next = pc + 32'd4;
    if_id.order   = ord;
    if_id.valid   = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    tick();
    tick();
    n_checks++; if (go !== 1'b1) $display("FAIL rst_go: got %b expected 1", go); else n_pass++;
    n_checks++; if (id_ex.valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", id_ex.valid); else n_pass++;
    n_checks++; if (id_ex.inst !== 32'h00000013) $display("FAIL rst_inst: got %h expected 00000013", id_ex.inst); else n_pass++;
    rst = 1'b0;
    tick();
    // Load id_ex with a valid entry and leave a second request outstanding
    issue(32'h00000100, 64'd7, 1'b1);
    tick();
    drive_idle();
    imem_resp  = 1'b1;
    imem_rdata = 32'h00500093;
    issue(32'h00000104, 64'd8, 1'b1);
    settle();
    n_checks++; if (go !== 1'b1) $display("FAIL b2b_go: got %b expected 1", go); else n_pass++;
    tick();
    drive_idle();
    n_checks++; if (id_ex.valid !== 1'b1 || id_ex.pc !== 32'h100) $display("FAIL b2b_emit: got valid=%b pc=%h expected 1/00000100", id_ex.valid, id_ex.pc); else n_pass++;
    settle();
    n_checks++; if (go !== 1'b0) $display("FAIL wait_go: got %b expected 0", go); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_checks++; if (go !== 1'b1) $display("FAIL async_rst_go: got %b expected 1", go); else n_pass++;
    n_checks++; if (id_ex.valid !== 1'b0) $display("FAIL async_rst_valid: got %b expected 0", id_ex.valid); else n_pass++;
    n_checks++; if (id_ex.inst !== 32'h00000013) $display("FAIL async_rst_inst: got %h expected 00000013", id_ex.inst); else n_pass++;
    #1 rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    drive_idle();
    issue(32'h1eceb000, 64'd0, 1'b1);
    settle();
    n_checks++; if (go !== 1'b1) $display("FAIL basic_idle_go: got %b expected 1", go); else n_pass++;
    tick();
    drive_idle();
    imem_resp  = 1'b1;
    imem_rdata = 32'h00500093;
    settle();
    n_checks++; if (go !== 1'b1) $display("FAIL basic_resp_go: got %b expected 1", go); else n_pass++;
    n_checks++; if (rs1_s !== 5'd0 || rs2_s !== 5'd0) $display("FAIL basic_rs: got rs1=%0d rs2=%0d expected 0/0", rs1_s, rs2_s); else n_pass++;
    tick();
    drive_idle();
    n_checks++; if (id_ex.valid !== 1'b1) $display("FAIL basic_valid: got %b expected 1", id_ex.valid); else n_pass++;
    n_checks++; if (id_ex.pc !== 32'h1eceb000 || id_ex.pc_next !== 32'h1eceb004) $display("FAIL basic_pc: got %h/%h expected 1eceb000/1eceb004", id_ex.pc, id_ex.pc_next); else n_pass++;
    n_checks++; if (id_ex.order !== 64'd0) $display("FAIL basic_order: got %0d expected 0", id_ex.order); else n_pass++;
    n_checks++; if (id_ex.rd_s !== 5'd1 || id_ex.rs1_s !== 5'd0 || id_ex.rs2_s !== 5'd0) $display("FAIL basic_regs: got rd=%0d rs1=%0d rs2=%0d expected 1/0/0", id_ex.rd_s, id_ex.rs1_s, id_ex.rs2_s); else n_pass++;
    n_checks++; if (id_ex.imm !== 32'd5) $display("FAIL basic_imm: got %h expected 00000005", id_ex.imm); else n_pass++;
    n_checks++; if (id_ex.opcode !== 7'h13 || id_ex.illegal !== 1'b0 || id_ex.inst !== 32'h00500093) $display("FAIL basic_op: got op=%h ill=%b inst=%h expected 13/0/00500093", id_ex.opcode, id_ex.illegal, id_ex.inst); else n_pass++;
    tick();
    n_checks++; if (id_ex.valid !== 1'b0) $display("FAIL basic_bubble: got %b expected 0", id_ex.valid); else n_pass++;
  endtask

  task automatic test_stall();
    drive_idle();
    issue(32'h00002000, 64'd5, 1'b1);
    tick();
    drive_idle();
    imem_resp  = 1'b1;
    imem_rdata = 32'h00500093;
    issue(32'h00003000, 64'd6, 1'b1);
    tick();
    drive_idle();
    n_checks++; if (id_ex.valid !== 1'b1 || id_ex.pc !== 32'h2000) $display("FAIL stall_pre: got valid=%b pc=%h expected 1/00002000", id_ex.valid, id_ex.pc); else n_pass++;
    imem_resp  = 1'b1;
    imem_rdata = 32'h0020a423;
    stall      = 1'b1;
    settle();
    n_checks++; if (go !== 1'b0) $display("FAIL stall_resp_go: got %b expected 0", go); else n_pass++;
    tick();
    imem_resp  = 1'b0;
    imem_rdata = 32'hdeadbeef;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (id_ex.valid !== 1'b1 || id_ex.pc !== 32'h2000) $display("FAIL stall_hold_%0d: got valid=%b pc=%h expected 1/00002000", i, id_ex.valid, id_ex.pc); else n_pass++;
      settle();
      n_checks++; if (go !== 1'b0) $display("FAIL stall_held_go_%0d: got %b expected 0", i, go); else n_pass++;
      tick();
    end
    n_checks++; if (id_ex.pc !== 32'h2000) $display("FAIL stall_hold_end: got pc=%h expected 00002000", id_ex.pc); else n_pass++;
    stall = 1'b0;
    settle();
    n_checks++; if (go !== 1'b1) $display("FAIL stall_release_go: got %b expected 1", go); else n_pass++;
    n_checks++; if (rs1_s !== 5'd1 || rs2_s !== 5'd2) $display("FAIL stall_release_rs: got rs1=%0d rs2=%0d expected 1/2", rs1_s, rs2_s); else n_pass++;
    tick();
    drive_idle();
    n_checks++; if (id_ex.valid !== 1'b1 || id_ex.pc !== 32'h3000 || id_ex.order !== 64'd6) $display("FAIL stall_emit_meta: got valid=%b pc=%h order=%0d expected 1/00003000/6", id_ex.valid, id_ex.pc, id_ex.order); else n_pass++;
    n_checks++; if (id_ex.inst !== 32'h0020a423) $display("FAIL stall_emit_inst: got %h expected 0020a423", id_ex.inst); else n_pass++;
    n_checks++; if (id_ex.imm !== 32'd8 || id_ex.rd_s !== 5'd0 || id_ex.rs1_s !== 5'd1 || id_ex.rs2_s !== 5'd2) $display("FAIL store_decode: got imm=%h rd=%0d rs1=%0d rs2=%0d expected 00000008/0/1/2", id_ex.imm, id_ex.rd_s, id_ex.rs1_s, id_ex.rs2_s); else n_pass++;
  endtask

  task automatic test_flush_wait();
    drive_idle();
    issue(32'h00004000, 64'd10, 1'b1);
    tick();
    drive_idle();
    flush = 1'b1;
    settle();
    n_checks++; if (go !== 1'b0) $display("FAIL flushw_go: got %b expected 0", go); else n_pass++;
    tick();
    drive_idle();
    n_checks++; if (id_ex.valid !== 1'b0) $display("FAIL flushw_bubble: got %b expected 0", id_ex.valid); else n_pass++;
    imem_resp  = 1'b1;
    imem_rdata = 32'h0020a423;
    settle();
    n_checks++; if (go !== 1'b1) $display("FAIL flushw_resp_go: got %b expected 1", go); else n_pass++;
    n_checks++; if (rs1_s !== 5'd0) $display("FAIL flushw_rs1: got %0d expected 0", rs1_s); else n_pass++;
    tick();
    drive_idle();
    n_checks++; if (id_ex.valid !== 1'b0) $display("FAIL flushw_discard: got %b expected 0", id_ex.valid); else n_pass++;
    settle();
    n_checks++; if (go !== 1'b1) $display("FAIL flushw_idle_go: got %b expected 1", go); else n_pass++;
    tick();
  endtask

  task automatic test_flush_issue();
    drive_idle();
    issue(32'h00005000, 64'd11, 1'b1);
    flush = 1'b1;
    settle();
    n_checks++; if (go !== 1'b1) $display("FAIL flushi_go: got %b expected 1", go); else n_pass++;
    tick();
    drive_idle();
    settle();
    n_checks++; if (go !== 1'b0) $display("FAIL flushi_kill_go: got %b expected 0", go); else n_pass++;
    tick();
    imem_resp  = 1'b1;
    imem_rdata = 32'h0020a423;
    issue(32'h00006000, 64'd12, 1'b1);
    settle();
    n_checks++; if (go !== 1'b1) $display("FAIL flushi_resp_go: got %b expected 1", go); else n_pass++;
    n_checks++; if (rs2_s !== 5'd0) $display("FAIL flushi_rs2: got %0d expected 0", rs2_s); else n_pass++;
    tick();
    drive_idle();
    n_checks++; if (id_ex.valid !== 1'b0) $display("FAIL flushi_discard: got %b expected 0", id_ex.valid); else n_pass++;
    imem_resp  = 1'b1;
    imem_rdata = 32'hfe000ee3;
    settle();
    n_checks++; if (go !== 1'b1) $display("FAIL flushi_next_go: got %b expected 1", go); else n_pass++;
    tick();
    drive_idle();
    n_checks++; if (id_ex.valid !== 1'b1 || id_ex.pc !== 32'h6000 || id_ex.order !== 64'd12) $display("FAIL flushi_next_meta: got valid=%b pc=%h order=%0d expected 1/00006000/12", id_ex.valid, id_ex.pc, id_ex.order); else n_pass++;
    n_checks++; if (id_ex.imm !== 32'hfffffffc || id_ex.rd_s !== 5'd0 || id_ex.opcode !== 7'h63) $display("FAIL branch_decode: got imm=%h rd=%0d op=%h expected fffffffc/0/63", id_ex.imm, id_ex.rd_s, id_ex.opcode); else n_pass++;
  endtask

  task automatic test_jal_illegal();
    drive_idle();
    issue(32'h00007000, 64'd13, 1'b1);
    tick();
    drive_idle();
    imem_resp  = 1'b1;
    imem_rdata = 32'h008000ef;
    issue(32'h00007004, 64'd14, 1'b1);
    tick();
    drive_idle();
    n_checks++; if (id_ex.pc !== 32'h7000 || id_ex.imm !== 32'd8 || id_ex.rd_s !== 5'd1 || id_ex.rs1_s !== 5'd0 || id_ex.illegal !== 1'b0) $display("FAIL jal_decode: got pc=%h imm=%h rd=%0d rs1=%0d ill=%b expected 00007000/00000008/1/0/0", id_ex.pc, id_ex.imm, id_ex.rd_s, id_ex.rs1_s, id_ex.illegal); else n_pass++;
    imem_resp  = 1'b1;
    imem_rdata = 32'hffffffff;
    tick();
    drive_idle();
    n_checks++; if (id_ex.valid !== 1'b1 || id_ex.pc !== 32'h7004 || id_ex.illegal !== 1'b1) $display("FAIL illegal_flag: got valid=%b pc=%h ill=%b expected 1/00007004/1", id_ex.valid, id_ex.pc, id_ex.illegal); else n_pass++;
    n_checks++; if (id_ex.imm !== 32'h0 || id_ex.rd_s !== 5'd0) $display("FAIL illegal_fields: got imm=%h rd=%0d expected 00000000/0", id_ex.imm, id_ex.rd_s); else n_pass++;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_basic();
    test_stall();
    test_flush_wait();
    test_flush_issue();
    test_jal_illegal();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
